pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the team's fixed-width gate-level CLA.
- The WIDTH-bit operand is split into GROUP-bit lookahead groups. Each group is resolved in its own pipeline stage, and the group carry is registered between stages.
- Has a valid/ready stream interface with backpressure, plus status flags. It sits in the ALU datapath where a wide add must meet timing at full throughput.

---
 rtl/alu_pkg.sv | 17 +
 rtl/cla_group.sv | 45 ++++
 rtl/pipelined_cla_adder.sv | 129 ++++++++++++
 tb/tb_pipelined_cla_adder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants, operation mode encoding and width sanity check.
package alu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } alu_mode_e;

  // Adder widths must split evenly into lookahead groups.
  function automatic bit group_divides(input int width, input int group);
    return (group > 0) && (width > 0) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GROUP-bit carry-lookahead slice.
module cla_group
  import alu_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  assign g = a & b;
  assign p = a | b;

  // Each carry is a flat sum of generate terms, not a ripple through c[i].
  always_comb begin
    logic acc;
    logic prop;
    c    = '0;
    acc  = 1'b0;
    prop = 1'b0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      acc  = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = acc | (prop & cin);
    end
  end

  assign sum   = a ^ b ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor, one group per stage.
module pipelined_cla_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             CI,
  input  logic             Sub,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic             CO,
  output logic             OF,
  output logic             Zero
);

  localparam int STAGES = WIDTH / GROUP;

  if (!group_divides(WIDTH, GROUP)) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
  end

  alu_mode_e mode;
  logic      adv;

  assign mode    = alu_mode_e'(Sub);
  assign adv     = !OutValid || OutReady;
  assign InReady = adv;

  // x words carry finished sum bits below the current group and raw A bits above it.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * GROUP;

    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] x_q;
    logic             c_in;
    logic             v_in;
    logic             c_q;
    logic             v_q;
    logic [GROUP-1:0] g_sum;
    logic             g_cout;
    logic             g_cmsb;

    if (k == 0) begin : g_src
      assign x_in = In1;
      assign b_in = (mode == MODE_SUB) ? ~In2 : In2;
      assign c_in = CI ^ (mode == MODE_SUB);
      assign v_in = InValid;
    end else begin : g_src
      assign x_in = g_stage[k-1].x_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
    end

    cla_group #(.GROUP(GROUP)) u_cla (
      .a    (x_in[LO +: GROUP]),
      .b    (b_in[LO +: GROUP]),
      .cin  (c_in),
      .sum  (g_sum),
      .cout (g_cout),
      .c_msb(g_cmsb)
    );

    always_comb begin
      x_d             = x_in;
      x_d[LO +: GROUP] = g_sum;
    end

    // Data only loads behind a valid beat, so bubbles leave the last result in place.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        x_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_in;
        if (v_in) begin
          x_q <= x_d;
          c_q <= g_cout;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] b_q;
      logic             unused_cmsb;

      assign unused_cmsb = g_cmsb;

      always_ff @(posedge clk) begin
        if (rst) begin
          b_q <= '0;
        end else if (adv && v_in) begin
          b_q <= b_in;
        end
      end
    end else begin : g_last
      logic of_q;
      logic unused_b;

      assign unused_b = ^b_in;

      always_ff @(posedge clk) begin
        if (rst) begin
          of_q <= 1'b0;
        end else if (adv && v_in) begin
          of_q <= g_cmsb ^ g_cout;
        end
      end
    end
  end

  assign OutValid = g_stage[STAGES-1].v_q;
  assign Out      = g_stage[STAGES-1].x_q;
  assign CO       = g_stage[STAGES-1].c_q;
  assign OF       = g_stage[STAGES-1].g_last.of_q;
  assign Zero     = OutValid && (Out == '0);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - self-checking bench for pipelined_cla_adder.
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        InValid;
  logic        InReady;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        CI;
  logic        Sub;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Out;
  logic        CO;
  logic        OF;
  logic        Zero;

  pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .InValid (InValid),
    .InReady (InReady),
    .In1     (In1),
    .In2     (In2),
    .CI      (CI),
    .Sub     (Sub),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Out     (Out),
    .CO      (CO),
    .OF      (OF),
    .Zero    (Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic [31:0] out;
    logic        co;
    logic        of;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    logic        co;
    logic        of;
    logic        zero;
  } res_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub);
    logic [31:0] bx;
    logic [32:0] s;
    res_t        r;
    bx     = sub ? ~b : b;
    s      = {1'b0, a} + {1'b0, bx} + 33'(ci ^ sub);
    r.out  = s[31:0];
    r.co   = s[32];
    r.of   = (a[31] == bx[31]) && (s[31] != a[31]);
    r.zero = (s[31:0] == 32'h0);
    return r;
  endfunction

  // Sends one beat and counts cycles until it emerges; clean stays 1 if flags were all 0 meanwhile.
  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input logic sub, output int lat, output bit clean);
    @(negedge clk);
    In1 = a; In2 = b; CI = ci; Sub = sub;
    InValid = 1'b1; OutReady = 1'b1;
    lat = 0; clean = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      InValid = 1'b0;
      if (OutValid) begin
        lat = c;
        break;
      end
      if (Out != 32'h0 || CO || OF || Zero) clean = 1'b0;
    end
  endtask

  task automatic run_stream(input int n, input bit rand_ready, input string tag,
                            output int first_cyc, output int last_cyc);
    res_t        expq[$];
    res_t        e;
    res_t        held;
    bit          hold_pending = 1'b0;
    bit          need_new = 1'b1;
    int          sent = 0;
    int          got = 0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ci = 1'b0;
    logic        sub = 1'b0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
      @(negedge clk);
      OutReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < n) begin
        if (need_new) begin
          a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
          need_new = 1'b0;
        end
        In1 = a; In2 = b; CI = ci; Sub = sub; InValid = 1'b1;
      end else begin
        InValid = 1'b0;
      end
      #1;
      if (hold_pending) begin
        check($sformatf("%s hold_valid c%0d", tag, cyc), 64'(OutValid), 64'd1);
        check($sformatf("%s hold_data c%0d", tag, cyc), 64'({Out, CO, OF, Zero}),
              64'({held.out, held.co, held.of, held.zero}));
      end
      check($sformatf("%s in_ready c%0d", tag, cyc), 64'(InReady), 64'(!OutValid || OutReady));
      if (InValid && InReady) begin
        expq.push_back(model(a, b, ci, sub));
        sent++;
        need_new = 1'b1;
      end
      if (OutValid && OutReady) begin
        check($sformatf("%s beat%0d expected", tag, got), 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check($sformatf("%s beat%0d out", tag, got), 64'(Out), 64'(e.out));
          check($sformatf("%s beat%0d flags", tag, got), 64'({CO, OF, Zero}),
                64'({e.co, e.of, e.zero}));
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      hold_pending = OutValid && !OutReady;
      held.out = Out; held.co = CO; held.of = OF; held.zero = Zero;
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    check($sformatf("%s beats_out", tag), 64'(got), 64'(n));
    check($sformatf("%s leftover", tag), 64'(expq.size()), 64'd0);
    repeat (3) @(negedge clk);
    check($sformatf("%s no_dup", tag), 64'(OutValid), 64'd0);
  endtask

  vec_t vecs[13];

  initial begin
    int lat;
    bit clean;
    int first_cyc;
    int last_cyc;
    int seen;

    vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{32'h00001234, 32'h00001234, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{32'h0000000F, 32'h00000001, 1'b0, 1'b0, 32'h00000010, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; InValid = 1'b0; In1 = '0; In2 = '0; CI = 1'b0; Sub = 1'b0; OutReady = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid", 64'(OutValid), 64'd0);
    check("reset out", 64'(Out), 64'd0);
    check("reset flags", 64'({CO, OF, Zero}), 64'd0);
    check("reset in_ready", 64'(InReady), 64'd1);

    foreach (vecs[i]) begin
      send_one(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, lat, clean);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd8);
      check($sformatf("vec%0d out", i), 64'(Out), 64'(vecs[i].out));
      check($sformatf("vec%0d co", i), 64'(CO), 64'(vecs[i].co));
      check($sformatf("vec%0d of", i), 64'(OF), 64'(vecs[i].of));
      check($sformatf("vec%0d zero", i), 64'(Zero), 64'(vecs[i].zero));
    end

    @(negedge clk);
    run_stream(20, 1'b0, "stream", first_cyc, last_cyc);
    check("stream first_out_cycle", 64'(first_cyc), 64'd8);
    check("stream last_out_cycle", 64'(last_cyc), 64'd27);

    run_stream(10, 1'b1, "bp", first_cyc, last_cyc);

    // Three beats in flight, then a one-cycle reset discards them.
    @(negedge clk);
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      In1 = 32'h100 + i; In2 = 32'h1; CI = 1'b0; Sub = 1'b0; InValid = 1'b1;
      @(negedge clk);
    end
    InValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst out_valid", 64'(OutValid), 64'd0);
    check("midrst out", 64'(Out), 64'd0);
    check("midrst flags", 64'({CO, OF, Zero}), 64'd0);
    check("midrst in_ready", 64'(InReady), 64'd1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (OutValid || Out != 32'h0 || CO || OF || Zero) seen++;
    end
    check("midrst flushed", 64'(seen), 64'd0);
    send_one(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, lat, clean);
    check("midrst new latency", 64'(lat), 64'd8);
    check("midrst quiet before", 64'(clean), 64'd1);
    check("midrst new out", 64'(Out), 64'h00010000);
    check("midrst new flags", 64'({CO, OF, Zero}), 64'd0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
